// File: rtl/gnss_capture_pkg.sv
// Shared types and defaults for the acquisition capture path.
package gnss_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned DEF_IN_W     = 8;
  localparam int unsigned DEF_OUT_BITS = 1;
  localparam int unsigned DEF_BIT_SEL  = 2;
  localparam int unsigned DEF_PACK_N   = 10;
  localparam int unsigned DEF_CNT_W    = 16;

  function automatic int unsigned pack_width(input int unsigned pack_n,
                                             input int unsigned out_bits);
    return pack_n * out_bits;
  endfunction

endpackage

// File: rtl/iq_bit_packer.sv
// Per-channel serial-in/parallel-out packer; samples land LSB-first.
module iq_bit_packer
  import gnss_capture_pkg::*;
#(
  parameter int unsigned OUT_BITS = DEF_OUT_BITS,
  parameter int unsigned PACK_N   = DEF_PACK_N
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_clr,
  input  logic                                     i_shift,
  input  logic [OUT_BITS-1:0]                      i_sample,
  output logic [pack_width(PACK_N, OUT_BITS)-1:0]  o_next
);

  localparam int unsigned W = pack_width(PACK_N, OUT_BITS);

  // Only the PACK_N-1 older samples are stored; the newest is taken straight
  // from the input so the full word is available on the last sample's edge.
  logic [W-OUT_BITS-1:0] r_sr;

  always_comb o_next = {i_sample, r_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= o_next[W-1:OUT_BITS];
    end
  end

endmodule

// File: rtl/iq_sample_packer.sv
// IQ sample quantiser/packer: bit-slices each sample, packs PACK_N per word,
// and emits a programmed number of word pairs per capture run.
module iq_sample_packer
  import gnss_capture_pkg::*;
#(
  parameter int unsigned IN_W     = DEF_IN_W,
  parameter int unsigned OUT_BITS = DEF_OUT_BITS,
  parameter int unsigned BIT_SEL  = DEF_BIT_SEL,
  parameter int unsigned PACK_N   = DEF_PACK_N,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [CNT_W-1:0]                         cfg_words,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  logic [IN_W-1:0]                          s_i,
  input  logic [IN_W-1:0]                          s_q,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [pack_width(PACK_N, OUT_BITS)-1:0]  m_i,
  output logic [pack_width(PACK_N, OUT_BITS)-1:0]  m_q,
  output logic                                     busy,
  output logic                                     done
);

  localparam int unsigned W    = pack_width(PACK_N, OUT_BITS);
  localparam int unsigned SC_W = $clog2(PACK_N);
  localparam logic [SC_W-1:0]  LAST_IDX = SC_W'(PACK_N - 1);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
  localparam logic [CNT_W-1:0] WC_ONE   = CNT_W'(1);

  if ((BIT_SEL + OUT_BITS > IN_W) || (OUT_BITS < 1) || (PACK_N < 2)) begin : g_bad_params
    $error("iq_sample_packer: illegal BIT_SEL/OUT_BITS/PACK_N combination");
  end

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cfg_words, r_word_cnt;
  logic [SC_W-1:0]   r_sample_cnt;
  logic              r_m_valid;
  logic [W-1:0]      r_m_i, r_m_q;
  logic [W-1:0]      w_word_i, w_word_q;
  logic              w_last, w_final, w_abort, w_s_ready, w_accept, w_load;

  always_comb begin
    w_last    = (r_sample_cnt == LAST_IDX);
    w_final   = ((r_word_cnt + WC_ONE) == r_cfg_words);
    w_abort   = abort && ((r_state == CAPTURE) || (r_state == DRAIN));
    // Stall only when the sample about to be taken would need the output
    // register while it still holds an unaccepted word.
    w_s_ready = (r_state == CAPTURE) && !(w_last && r_m_valid && !m_ready);
    w_accept  = s_valid && w_s_ready && !w_abort;
    w_load    = w_accept && w_last;
  end

  always_comb begin
    w_next = r_state;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (cfg_words == '0) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        if (w_abort)                w_next = IDLE;
        else if (w_load && w_final) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_abort)                   w_next = IDLE;
        else if (r_m_valid && m_ready) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cfg_words  <= '0;
      r_word_cnt   <= '0;
      r_sample_cnt <= '0;
      r_m_valid    <= 1'b0;
      r_m_i        <= '0;
      r_m_q        <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && start) begin
        r_cfg_words  <= cfg_words;
        r_word_cnt   <= '0;
        r_sample_cnt <= '0;
      end
      if (w_abort) begin
        r_word_cnt   <= '0;
        r_sample_cnt <= '0;
        r_m_valid    <= 1'b0;
      end else begin
        if (w_accept) r_sample_cnt <= w_last ? '0 : r_sample_cnt + SC_ONE;
        if (w_load) begin
          r_word_cnt <= r_word_cnt + WC_ONE;
          r_m_i      <= w_word_i;
          r_m_q      <= w_word_q;
          r_m_valid  <= 1'b1;
        end else if (m_ready) begin
          r_m_valid  <= 1'b0;
        end
      end
    end
  end

  iq_bit_packer #(.OUT_BITS(OUT_BITS), .PACK_N(PACK_N)) u_pack_i (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_abort),
    .i_shift  (w_accept),
    .i_sample (s_i[BIT_SEL +: OUT_BITS]),
    .o_next   (w_word_i)
  );

  iq_bit_packer #(.OUT_BITS(OUT_BITS), .PACK_N(PACK_N)) u_pack_q (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_abort),
    .i_shift  (w_accept),
    .i_sample (s_q[BIT_SEL +: OUT_BITS]),
    .o_next   (w_word_q)
  );

  always_comb begin
    s_ready = w_s_ready;
    m_valid = r_m_valid;
    m_i     = r_m_i;
    m_q     = r_m_q;
    busy    = (r_state != IDLE);
  end

endmodule

// File: tb/tb_iq_sample_packer.sv
// Scoreboard bench for iq_sample_packer: default build (A) and a 2-bit/PACK_N=4 build (B).
module tb_iq_sample_packer;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned A_OB = 1, A_BS = 2, A_PN = 10, A_W = 10;
  localparam int unsigned B_OB = 2, B_BS = 6, B_PN = 4,  B_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             a_start, a_abort, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_busy, a_done;
  logic [CNT_W-1:0] a_cfg;
  logic [IN_W-1:0]  a_si, a_sq;
  logic [A_W-1:0]   a_mi, a_mq;

  logic             b_start, b_abort, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_busy, b_done;
  logic [CNT_W-1:0] b_cfg;
  logic [IN_W-1:0]  b_si, b_sq;
  logic [B_W-1:0]   b_mi, b_mq;

  iq_sample_packer dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .cfg_words(a_cfg),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_i(a_si), .s_q(a_sq),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_i(a_mi), .m_q(a_mq),
    .busy(a_busy), .done(a_done)
  );

  iq_sample_packer #(.IN_W(IN_W), .OUT_BITS(B_OB), .BIT_SEL(B_BS), .PACK_N(B_PN), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .cfg_words(b_cfg),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_i(b_si), .s_q(b_sq),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_i(b_mi), .m_q(b_mq),
    .busy(b_busy), .done(b_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- models ----------------
  logic [2*A_W-1:0] a_exp_q[$];
  logic [2*B_W-1:0] b_exp_q[$];
  logic [2*B_W-1:0] b_got[$];
  int               a_k = 0, b_k = 0, a_acc_total = 0;
  logic [A_W-1:0]   a_acc_i = '0, a_acc_q = '0;
  logic [B_W-1:0]   b_acc_i = '0, b_acc_q = '0;

  task automatic a_model_accept(input logic [IN_W-1:0] si, input logic [IN_W-1:0] sq);
    a_acc_i[a_k*A_OB +: A_OB] = si[A_BS +: A_OB];
    a_acc_q[a_k*A_OB +: A_OB] = sq[A_BS +: A_OB];
    a_acc_total++;
    a_k++;
    if (a_k == A_PN) begin
      a_exp_q.push_back({a_acc_i, a_acc_q});
      a_k = 0;
    end
  endtask

  task automatic b_model_accept(input logic [IN_W-1:0] si, input logic [IN_W-1:0] sq);
    b_acc_i[b_k*B_OB +: B_OB] = si[B_BS +: B_OB];
    b_acc_q[b_k*B_OB +: B_OB] = sq[B_BS +: B_OB];
    b_k++;
    if (b_k == B_PN) begin
      b_exp_q.push_back({b_acc_i, b_acc_q});
      b_k = 0;
    end
  endtask

  // ---------------- monitors ----------------
  int             a_words = 0, a_done_cnt = 0, a_done_cyc = 0, a_last_hs_cyc = 0, b_done_cnt = 0;
  logic [A_W-1:0] a_last_mi = '0, a_last_mq = '0, a_hold_i = '0, a_hold_q = '0;
  bit             a_holding = 0;

  always @(negedge clk) begin : mon_a
    logic [2*A_W-1:0] e;
    if (rst) begin
      a_holding = 0;
    end else begin
      if (a_holding) begin
        check("a_hold_valid", a_m_valid, 1'b1);
        check("a_hold_data", {a_mi, a_mq}, {a_hold_i, a_hold_q});
      end
      if (a_done) begin
        a_done_cnt++;
        a_done_cyc = cyc;
      end
      if (a_m_valid && a_m_ready) begin
        check("a_sb_nonempty", (a_exp_q.size() != 0), 1'b1);
        if (a_exp_q.size() != 0) begin
          e = a_exp_q.pop_front();
          check("a_word", {a_mi, a_mq}, e);
        end
        a_words++;
        a_last_hs_cyc = cyc;
        a_last_mi = a_mi;
        a_last_mq = a_mq;
      end
      a_holding = a_m_valid && !a_m_ready;
      a_hold_i  = a_mi;
      a_hold_q  = a_mq;
    end
  end

  always @(negedge clk) begin : mon_b
    logic [2*B_W-1:0] e;
    if (!rst) begin
      if (b_done) b_done_cnt++;
      if (b_m_valid && b_m_ready) begin
        check("b_sb_nonempty", (b_exp_q.size() != 0), 1'b1);
        if (b_exp_q.size() != 0) begin
          e = b_exp_q.pop_front();
          check("b_word", {b_mi, b_mq}, e);
        end
        b_got.push_back({b_mi, b_mq});
      end
    end
  end

  // ---------------- drivers (all entered and left at posedge+1) ----------------
  task automatic a_start_run(input logic [CNT_W-1:0] n);
    a_cfg = n;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_send(input logic [IN_W-1:0] si, input logic [IN_W-1:0] sq);
    a_si = si;
    a_sq = sq;
    a_s_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (a_s_ready) begin
        a_model_accept(si, sq);
        @(posedge clk); #1;
        a_s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("a_send_timeout", a_s_ready, 1'b1);
    a_s_valid = 1'b0;
  endtask

  task automatic a_wait_done(input string tag, input int cnt0);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); #1;
      if (a_done_cnt != cnt0) begin
        @(posedge clk); #1;
        return;
      end
    end
    check(tag, a_done_cnt - cnt0, 1);
  endtask

  task automatic b_send(input logic [IN_W-1:0] si, input logic [IN_W-1:0] sq);
    b_si = si;
    b_sq = sq;
    b_s_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (b_s_ready) begin
        b_model_accept(si, sq);
        @(posedge clk); #1;
        b_s_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("b_send_timeout", b_s_ready, 1'b1);
    b_s_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w0, d0, base, sc;
    bit any_ready;
    logic [IN_W-1:0] v1, v2;

    rst = 1'b1;
    a_start = 0; a_abort = 0; a_cfg = '0; a_s_valid = 0; a_si = '0; a_sq = '0; a_m_ready = 1'b1;
    b_start = 0; b_abort = 0; b_cfg = '0; b_s_valid = 0; b_si = '0; b_sq = '0; b_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", a_s_ready, 1'b0);
    check("rst_m_valid", a_m_valid, 1'b0);
    check("rst_m_data", {a_mi, a_mq}, '0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // constant pattern, two words
    w0 = a_words; d0 = a_done_cnt;
    a_start_run(16'd2);
    check("t1_busy", a_busy, 1'b1);
    for (int i = 0; i < 20; i++) a_send(8'h04, 8'hFB);
    a_wait_done("t1_done_timeout", d0);
    check("t1_words", a_words - w0, 2);
    check("t1_mi", a_last_mi, 10'h3FF);
    check("t1_mq", a_last_mq, 10'h000);
    check("t1_done_lat", a_done_cyc - a_last_hs_cyc, 1);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_once", a_done_cnt - d0, 1);
    check("t1_idle", a_busy, 1'b0);

    // alternating bit2, valid latency
    d0 = a_done_cnt;
    a_start_run(16'd1);
    for (int k = 0; k < 10; k++) begin
      if (k == 9) check("t2_valid_early", a_m_valid, 1'b0);
      a_send((k % 2 == 0) ? 8'h04 : 8'h00, 8'h00);
      if (k == 9) check("t2_valid_lat", a_m_valid, 1'b1);
    end
    a_wait_done("t2_done_timeout", d0);
    check("t2_mi", a_last_mi, 10'h155);

    // backpressure across two words
    d0 = a_done_cnt; w0 = a_words; base = a_acc_total;
    a_m_ready = 1'b0;
    a_start_run(16'd2);
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          v1 = 8'($urandom);
          v2 = 8'($urandom);
          a_send(v1, v2);
        end
      end
      begin
        for (int t = 0; t < 200 && (a_acc_total - base) < 19; t++) begin
          @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        check("t3_stall_ready", a_s_ready, 1'b0);
        check("t3_stall_count", a_acc_total - base, 19);
        check("t3_stall_valid", a_m_valid, 1'b1);
        @(posedge clk); #1;
        a_m_ready = 1'b1;
      end
    join
    a_wait_done("t3_done_timeout", d0);
    check("t3_words", a_words - w0, 2);
    check("t3_sb_empty", a_exp_q.size(), 0);

    // abort mid second word, then fresh run
    d0 = a_done_cnt; w0 = a_words;
    a_start_run(16'd2);
    for (int i = 0; i < 10; i++) a_send(8'h04, 8'h00);
    for (int i = 0; i < 5; i++)  a_send(8'h00, 8'h04);
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    a_k = 0;
    check("t4_abort_busy", a_busy, 1'b0);
    check("t4_abort_valid", a_m_valid, 1'b0);
    check("t4_abort_ready", a_s_ready, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t4_no_done", a_done_cnt - d0, 0);
    check("t4_first_word", a_words - w0, 1);
    a_start_run(16'd1);
    for (int i = 0; i < 10; i++) a_send(8'h04, 8'h04);
    a_wait_done("t4_done_timeout", d0);
    check("t4_fresh_mi", a_last_mi, 10'h3FF);
    check("t4_fresh_mq", a_last_mq, 10'h3FF);

    // asynchronous reset mid-capture
    a_start_run(16'd3);
    for (int i = 0; i < 4; i++) a_send(8'h04, 8'h04);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_s_ready", a_s_ready, 1'b0);
    check("t5_rst_valid", a_m_valid, 1'b0);
    check("t5_rst_data", {a_mi, a_mq}, '0);
    check("t5_rst_busy", a_busy, 1'b0);
    check("t5_rst_done", a_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_k = 0;
    a_exp_q.delete();
    @(posedge clk); #1;

    // zero-length run
    d0 = a_done_cnt; any_ready = 0;
    sc = cyc;
    a_start_run(16'd0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      any_ready |= a_s_ready;
    end
    @(posedge clk); #1;
    check("t6_no_ready", any_ready, 1'b0);
    check("t6_done_once", a_done_cnt - d0, 1);
    check("t6_done_lat", a_done_cyc - sc, 1);

    // 2-bit slice, PACK_N=4 build
    b_cfg = 16'd2;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) b_send(8'hC0, 8'h40);
    for (int i = 0; i < 4; i++) b_send(8'h40, 8'hC0);
    for (int t = 0; t < 50 && b_done_cnt == 0; t++) begin
      @(negedge clk); #1;
    end
    check("b_done", b_done_cnt, 1);
    check("b_count", b_got.size(), 2);
    if (b_got.size() == 2) begin
      check("b_word0", b_got[0], 16'hFF55);
      check("b_word1", b_got[1], 16'h55FF);
    end
    check("a_sb_final_empty", a_exp_q.size(), 0);
    check("b_sb_final_empty", b_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
